decode_imm_stage: RTL and testbench

//  Decode register stage that feeds the immediate extender (EXTENSOR).

---
 rtl/rv_dec_pkg.sv | 43 ++++
 rtl/rv_field_decode.sv | 42 ++++
 rtl/decode_imm_stage.sv | 117 +++++++++++
 tb/tb_decode_imm_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_dec_pkg.sv
// Shared definitions for the decode/immediate stage: opcodes, extender
// select codes, the decoded-field record and the skid buffer states.
package rv_dec_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;

    localparam logic [1:0] IMM_SEL_I  = 2'b00;
    localparam logic [1:0] IMM_SEL_S  = 2'b01;
    localparam logic [1:0] IMM_SEL_B  = 2'b10;
    localparam logic [1:0] IMM_SEL_UJ = 2'b11;

    // Everything the next stage needs, stored per buffer entry so the
    // outputs come straight from flops.
    typedef struct packed {
        logic [11:0] imm_i;
        logic [11:0] imm_s;
        logic [11:0] imm_b;
        logic [19:0] imm_uj;
        logic [1:0]  imm_sel;
        logic        imm_used;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic        illegal;
    } dec_fields_t;

    // Occupancy of the 2-entry skid buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/rv_field_decode.sv
// Purely combinational split of an instruction word into the raw immediate
// fields, extender select and register/opcode fields.
module rv_field_decode
    import rv_dec_pkg::*;
(
    input  logic [31:0] instr,
    output dec_fields_t fields
);

    // Raw fields are always extracted; the opcode only picks select/flags
    // and whether the 20-bit field uses U or J bit ordering.
    always_comb begin
        fields          = '0;
        fields.imm_i    = instr[31:20];
        fields.imm_s    = {instr[31:25], instr[11:7]};
        fields.imm_b    = {instr[31], instr[7], instr[30:25], instr[11:8]};
        fields.imm_uj   = instr[31:12];
        fields.imm_sel  = IMM_SEL_I;
        fields.imm_used = 1'b1;
        fields.illegal  = 1'b0;
        fields.rs1      = instr[19:15];
        fields.rs2      = instr[24:20];
        fields.rd       = instr[11:7];
        fields.opcode   = instr[6:0];
        case (instr[6:0])
            OP_IMM, LOAD, JALR: fields.imm_sel = IMM_SEL_I;
            STORE:              fields.imm_sel = IMM_SEL_S;
            BRANCH:             fields.imm_sel = IMM_SEL_B;
            LUI, AUIPC:         fields.imm_sel = IMM_SEL_UJ;
            JAL: begin
                fields.imm_sel = IMM_SEL_UJ;
                fields.imm_uj  = {instr[31], instr[19:12], instr[20], instr[30:21]};
            end
            OP:                 fields.imm_used = 1'b0;
            default: begin
                fields.illegal  = 1'b1;
                fields.imm_used = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/decode_imm_stage.sv
// Decode register stage in front of the immediate extender: field decoder,
// 2-entry skid buffer of decoded records, and an output-handshake counter.
module decode_imm_stage
    import rv_dec_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      imm_i,
    output logic [11:0]      imm_s,
    output logic [11:0]      imm_b,
    output logic [19:0]      imm_uj,
    output logic [1:0]       imm_sel,
    output logic             imm_used,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [6:0]       opcode,
    output logic             illegal,
    output logic [CNT_W-1:0] dec_count
);

    buf_state_e       state_q, state_d;
    dec_fields_t      head_q, head_d;
    dec_fields_t      tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    dec_fields_t      dec_in;
    logic             in_hs;
    logic             out_hs;

    rv_field_decode u_decode (
        .instr  (in_instr),
        .fields (dec_in)
    );

    assign in_ready  = (state_q != BUF_FULL);
    assign out_valid = (state_q != BUF_EMPTY);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    // Next-state logic: flush wins and leaves the data registers untouched,
    // so the field outputs keep showing the last head while out_valid is low.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            if (out_hs) begin
                count_d = count_q + 1'b1;
            end
            case (state_q)
                BUF_EMPTY: begin
                    if (in_hs) begin
                        head_d  = dec_in;
                        state_d = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (in_hs && out_hs) begin
                        head_d = dec_in;
                    end else if (in_hs) begin
                        tail_d  = dec_in;
                        state_d = BUF_FULL;
                    end else if (out_hs) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (out_hs) begin
                        head_d  = tail_q;
                        state_d = BUF_ONE;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

    // State, buffer entries and counter; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign imm_i     = head_q.imm_i;
    assign imm_s     = head_q.imm_s;
    assign imm_b     = head_q.imm_b;
    assign imm_uj    = head_q.imm_uj;
    assign imm_sel   = head_q.imm_sel;
    assign imm_used  = head_q.imm_used;
    assign rs1       = head_q.rs1;
    assign rs2       = head_q.rs2;
    assign rd        = head_q.rd;
    assign opcode    = head_q.opcode;
    assign illegal   = head_q.illegal;
    assign dec_count = count_q;

endmodule

// File: tb/tb_decode_imm_stage.sv
// Directed testbench for decode_imm_stage with hand-computed expectations.
module tb_decode_imm_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] imm_i;
    logic [11:0] imm_s;
    logic [11:0] imm_b;
    logic [19:0] imm_uj;
    logic [1:0]  imm_sel;
    logic        imm_used;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic        illegal;
    logic [15:0] dec_count;

    int compared   = 0;
    int mismatched = 0;

    decode_imm_stage #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm_i     (imm_i),
        .imm_s     (imm_s),
        .imm_b     (imm_b),
        .imm_uj    (imm_uj),
        .imm_sel   (imm_sel),
        .imm_used  (imm_used),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .opcode    (opcode),
        .illegal   (illegal),
        .dec_count (dec_count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic rdy, input logic fl);
        in_valid  = v;
        in_instr  = instr;
        out_ready = rdy;
        flush     = fl;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Linear directed sequence.
    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        // Reset values
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_count", dec_count, 0);
        checkOutput("rst_imm_sel", imm_sel, 0);
        checkOutput("rst_imm_i", imm_i, 0);
        #6 rst_n = 1'b1;
        tick();
        checkOutput("idle_out_valid", out_valid, 0);
        checkOutput("idle_in_ready", in_ready, 1);

        // addi x1,x0,-1 then a stream through I/S/B/J/U
        applyStimulus(1'b1, 32'hFFF00093, 1'b1, 1'b0);
        tick();
        checkOutput("addi_valid", out_valid, 1);
        checkOutput("addi_imm_i", imm_i, 32'hFFF);
        checkOutput("addi_sel", imm_sel, 0);
        checkOutput("addi_rd", rd, 1);
        checkOutput("addi_used", imm_used, 1);
        applyStimulus(1'b1, 32'h00112623, 1'b1, 1'b0);
        tick();
        checkOutput("sw_imm_s", imm_s, 32'h00C);
        checkOutput("sw_sel", imm_sel, 1);
        checkOutput("sw_rs1", rs1, 2);
        checkOutput("sw_rs2", rs2, 1);
        checkOutput("sw_count", dec_count, 1);
        // {b31=1, b7=1, b30:25=111111, b11:8=1110} = 0xFFE
        applyStimulus(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
        tick();
        checkOutput("beq_imm_b", imm_b, 32'hFFE);
        checkOutput("beq_sel", imm_sel, 2);
        applyStimulus(1'b1, 32'h0040006F, 1'b1, 1'b0);
        tick();
        checkOutput("jal_imm_uj", imm_uj, 32'h00002);
        checkOutput("jal_sel", imm_sel, 3);
        applyStimulus(1'b1, 32'h123450B7, 1'b1, 1'b0);
        tick();
        checkOutput("lui_imm_uj", imm_uj, 32'h12345);
        checkOutput("lui_sel", imm_sel, 3);
        checkOutput("lui_count", dec_count, 4);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("drain_valid", out_valid, 0);
        checkOutput("drain_count", dec_count, 5);

        // Backpressure with three offered instructions
        rst_n = 1'b0;
        #1;
        checkOutput("rst2_count", dec_count, 0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h00500113, 1'b0, 1'b0);
        tick();
        checkOutput("bp1_ready", in_ready, 1);
        applyStimulus(1'b1, 32'h00A00193, 1'b0, 1'b0);
        tick();
        checkOutput("bp2_ready", in_ready, 0);
        checkOutput("bp2_head", imm_i, 32'h005);
        applyStimulus(1'b1, 32'h00F00213, 1'b0, 1'b0);
        tick();
        checkOutput("bp3_ready", in_ready, 0);
        checkOutput("bp3_head", imm_i, 32'h005);
        checkOutput("bp3_rd", rd, 2);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("bp_drain1_head", imm_i, 32'h00A);
        checkOutput("bp_drain1_valid", out_valid, 1);
        checkOutput("bp_drain1_ready", in_ready, 1);
        tick();
        checkOutput("bp_drain2_valid", out_valid, 0);
        checkOutput("bp_count", dec_count, 2);

        // Flush a FULL buffer with both handshakes offered
        applyStimulus(1'b1, 32'h00500113, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h00A00193, 1'b0, 1'b0);
        tick();
        checkOutput("fl_full_ready", in_ready, 0);
        applyStimulus(1'b1, 32'h00F00213, 1'b1, 1'b1);
        tick();
        checkOutput("fl_valid", out_valid, 0);
        checkOutput("fl_ready", in_ready, 1);
        checkOutput("fl_count", dec_count, 2);
        applyStimulus(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        tick();
        checkOutput("ill_valid", out_valid, 1);
        checkOutput("ill_flag", illegal, 1);
        checkOutput("ill_used", imm_used, 0);
        checkOutput("ill_sel", imm_sel, 0);
        applyStimulus(1'b1, 32'h002081B3, 1'b1, 1'b0);
        tick();
        checkOutput("add_used", imm_used, 0);
        checkOutput("add_illegal", illegal, 0);
        checkOutput("add_count", dec_count, 3);

        // Counter wrap: first edge fills, each later edge is one handshake
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 32'h00000013, 1'b1, 1'b0);
        repeat (65536) tick();
        checkOutput("wrap_pre", dec_count, 32'hFFFF);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("wrap_zero", dec_count, 0);
        checkOutput("wrap_valid", out_valid, 0);

        // Asynchronous reset in the middle of a stream
        applyStimulus(1'b1, 32'hFFF00093, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("mid_count", dec_count, 1);
        checkOutput("mid_imm_i", imm_i, 32'hFFF);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", out_valid, 0);
        checkOutput("arst_ready", in_ready, 1);
        checkOutput("arst_imm_i", imm_i, 0);
        checkOutput("arst_rd", rd, 0);
        checkOutput("arst_opcode", opcode, 0);
        checkOutput("arst_count", dec_count, 0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
